// File: rtl/check_scan_if.sv
// Byte stream handshake between the scanner (master) and its consumer (slave).
interface check_scan_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/check_scan.sv
// Debug-word scanner: snapshots N_ENTRIES words through the upstream select mux,
// then streams HEADER, the words MSB first, and an XOR checksum of the data bytes.
module check_scan #(
    parameter int unsigned N_ENTRIES = 29,
    parameter logic [7:0]  HEADER    = 8'hA5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    output logic [4:0]    check_addr,
    input  logic [31:0]   check_data,
    check_scan_if.master  tx,
    output logic          busy,
    output logic          done
);

    localparam int unsigned POS_W    = 8;
    localparam logic [POS_W-1:0] DATA_END = POS_W'(4 * N_ENTRIES);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(4 * N_ENTRIES + 1);
    localparam logic [4:0]       LAST_IDX = 5'(N_ENTRIES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

    state_t             state_q;
    logic [4:0]         idx_q;
    logic [POS_W-1:0]   pos_q;
    logic [7:0]         chk_q;
    logic [7:0]         tx_data_q;
    logic               tx_valid_q;
    logic               busy_q;
    logic               done_q;
    logic [31:0]        buf_q [N_ENTRIES];

    logic [POS_W-1:0]   pos_d;
    logic [4:0]         word_idx;
    logic [31:0]        sel_word;
    logic [7:0]         next_byte;
    logic [7:0]         word_xor;

    // Byte that follows the one currently presented; pos_q doubles as the data byte offset.
    always_comb begin
        pos_d    = pos_q + POS_W'(1);
        word_idx = 5'(pos_q >> 2);
        sel_word = '0;
        if (pos_q < DATA_END) begin
            sel_word = buf_q[word_idx];
        end
        case (pos_q[1:0])
            2'd0:    next_byte = sel_word[31:24];
            2'd1:    next_byte = sel_word[23:16];
            2'd2:    next_byte = sel_word[15:8];
            default: next_byte = sel_word[7:0];
        endcase
        if (pos_d == LAST_POS) begin
            next_byte = chk_q;
        end
        word_xor = check_data[31:24] ^ check_data[23:16] ^ check_data[15:8] ^ check_data[7:0];
    end

    // Frame sequencer with registered stream and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pos_q      <= '0;
            chk_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    idx_q <= '0;
                    if (start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                        chk_q   <= '0;
                    end
                end
                SCAN: begin
                    chk_q <= chk_q ^ word_xor;
                    if (idx_q == LAST_IDX) begin
                        idx_q      <= '0;
                        pos_q      <= '0;
                        state_q    <= SEND;
                        tx_data_q  <= HEADER;
                        tx_valid_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 5'd1;
                    end
                end
                SEND: begin
                    if (tx_valid_q && tx.tx_ready) begin
                        if (pos_q == LAST_POS) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            pos_q     <= pos_d;
                            tx_data_q <= next_byte;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Snapshot buffer; only written while scanning, contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (state_q == SCAN) begin
            buf_q[idx_q] <= check_data;
        end
    end

    assign check_addr  = idx_q;
    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_check_scan.sv
// Randomized bench for check_scan against a frame-level reference model.
module tb_check_scan;

    localparam int unsigned N  = 29;
    localparam int unsigned NB = 4 * N + 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [4:0]  check_addr;
    logic [31:0] check_data;
    logic        busy;
    logic        done;
    logic [31:0] table_q [32];

    int n_checks = 0;
    int n_errors = 0;

    check_scan_if tx_if ();

    check_scan #(.N_ENTRIES(N), .HEADER(8'hA5)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .check_addr (check_addr),
        .check_data (check_data),
        .tx         (tx_if),
        .busy       (busy),
        .done       (done)
    );

    // Upstream debug-select mux model.
    assign check_data = table_q[check_addr];

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_table(input bit counting);
        for (int i = 0; i < 32; i++) begin
            table_q[i] = counting ? (32'h1000_0000 + 32'(i)) : $urandom;
        end
    endtask

    task automatic start_frame(input bit hold);
        @(negedge clk);
        check_eq("pre_start_busy", 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Runs from the first SCAN cycle (at a negedge) until done or abort.
    // mode: 0 ready=1, 1 ready toggles, 2 stall 50 cycles on first byte, 3 random ready.
    task automatic run_frame(input int mode, input bit mutate, input int reset_at, input bit hold);
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] chk;
        logic [7:0] b;
        logic [7:0] prev_data;
        bit         prev_stall;
        bit         fin;
        bit         aborted;
        bit         mutated;
        bit         r;
        int         stalls;
        int         k;

        exp_q.push_back(8'hA5);
        chk = 8'h00;
        for (int i = 0; i < N; i++) begin
            for (int j = 3; j >= 0; j--) begin
                b = table_q[i][8*j +: 8];
                exp_q.push_back(b);
                chk ^= b;
            end
        end
        exp_q.push_back(chk);

        prev_stall = 1'b0;
        prev_data  = 8'h00;
        fin        = 1'b0;
        aborted    = 1'b0;
        mutated    = 1'b0;
        stalls     = 0;
        k          = 0;

        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            if (k < int'(N)) begin
                check_eq("scan_addr", 32'(check_addr), 32'(k));
                check_eq("scan_busy", 32'(busy), 32'd1);
                check_eq("scan_valid", 32'(tx_if.tx_valid), 32'd0);
            end else begin
                check_eq("send_addr_zero", 32'(check_addr), 32'd0);
            end
            if (prev_stall) begin
                check_eq("stall_valid", 32'(tx_if.tx_valid), 32'd1);
                check_eq("stall_data", 32'(tx_if.tx_data), 32'(prev_data));
            end
            if (done) begin
                fin = 1'b1;
                check_eq("done_busy", 32'(busy), 32'd0);
                check_eq("done_valid", 32'(tx_if.tx_valid), 32'd0);
            end else if (reset_at >= 0 && tx_if.tx_valid && got_q.size() == reset_at) begin
                rstn = 1'b0;
                #1;
                check_eq("rst_valid", 32'(tx_if.tx_valid), 32'd0);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_done", 32'(done), 32'd0);
                check_eq("rst_addr", 32'(check_addr), 32'd0);
                check_eq("rst_data", 32'(tx_if.tx_data), 32'd0);
                tx_if.tx_ready = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("rst_hold_valid", 32'(tx_if.tx_valid), 32'd0);
                    check_eq("rst_hold_done", 32'(done), 32'd0);
                end
                rstn = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("post_rst_idle", 32'(busy), 32'd0);
                    check_eq("post_rst_valid", 32'(tx_if.tx_valid), 32'd0);
                    check_eq("post_rst_done", 32'(done), 32'd0);
                end
                aborted = 1'b1;
                fin     = 1'b1;
            end else begin
                if (mutate && tx_if.tx_valid && !mutated) begin
                    for (int i = 0; i < 32; i++) table_q[i] = $urandom;
                    mutated = 1'b1;
                end
                case (mode)
                    0: r = 1'b1;
                    1: r = (cyc % 2) == 0;
                    2: begin
                        if (tx_if.tx_valid && stalls < 50) begin
                            check_eq("stall50_data", 32'(tx_if.tx_data), 32'h0000_00A5);
                            r = 1'b0;
                            stalls++;
                        end else begin
                            r = 1'b1;
                        end
                    end
                    default: r = 1'($urandom_range(0, 1));
                endcase
                tx_if.tx_ready = r;
                if (tx_if.tx_valid && r) got_q.push_back(tx_if.tx_data);
                prev_stall = tx_if.tx_valid && !r;
                prev_data  = tx_if.tx_data;
            end
            k++;
            if (!fin) @(negedge clk);
        end

        check_eq("frame_timeout", 32'(fin), 32'd1);
        if (!aborted) begin
            check_eq("byte_count", 32'(got_q.size()), 32'(NB));
            for (int i = 0; i < int'(NB) && i < got_q.size(); i++) begin
                check_eq($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
            end
            tx_if.tx_ready = 1'b1;
            @(negedge clk);
            check_eq("idle_after_done", 32'(busy), 32'd0);
            check_eq("done_single", 32'(done), 32'd0);
            check_eq("idle_addr", 32'(check_addr), 32'd0);
            if (hold) begin
                @(negedge clk);
                check_eq("rescan_busy", 32'(busy), 32'd1);
                check_eq("rescan_addr", 32'(check_addr), 32'd0);
            end
        end
    endtask

    initial begin
        rstn           = 1'b0;
        start          = 1'b0;
        tx_if.tx_ready = 1'b1;
        fill_table(1'b1);
        #1;
        check_eq("reset_valid", 32'(tx_if.tx_valid), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_addr", 32'(check_addr), 32'd0);
        check_eq("reset_data", 32'(tx_if.tx_data), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_no_start", 32'(busy), 32'd0);

        // Counting pattern, always ready.
        start_frame(1'b0);
        run_frame(0, 1'b0, -1, 1'b0);

        // Same pattern with ready toggling.
        start_frame(1'b0);
        run_frame(1, 1'b0, -1, 1'b0);

        // Long stall on the header byte.
        fill_table(1'b0);
        start_frame(1'b0);
        run_frame(2, 1'b0, -1, 1'b0);

        // Upstream data changes during SEND.
        fill_table(1'b0);
        start_frame(1'b0);
        run_frame(3, 1'b1, -1, 1'b0);

        // Reset mid-SEND, then a clean frame.
        fill_table(1'b0);
        start_frame(1'b0);
        run_frame(3, 1'b0, 40, 1'b0);
        fill_table(1'b0);
        start_frame(1'b0);
        run_frame(0, 1'b0, -1, 1'b0);

        // Start held high: back-to-back frames.
        fill_table(1'b0);
        start_frame(1'b1);
        run_frame(3, 1'b0, -1, 1'b1);
        start = 1'b0;
        run_frame(0, 1'b0, -1, 1'b0);

        // Random frames with random backpressure.
        for (int f = 0; f < 3; f++) begin
            fill_table(1'b0);
            start_frame(1'b0);
            run_frame(3, 1'b0, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
